lfst_multi: RTL and testbench
=============================

// Module: lfst_multi
// PURPOSE
//  Parametrised last-fetched-store table for store-set memory dependence prediction, in the rename stage.
//  Each entry is indexed by SSID and holds the tag (phys reg / LSQ id) of the youngest renamed store in that set.
//  Adds features over the fixed 4-port table:
//   - configurable depth and width
//   - intra-bundle bypass from earlier update slots to later lookups
//   - tag-match invalidate on store retire
//   - periodic whole-table clear
// PARAMETERS
//  SSID_W     7      SSID width; table depth = 2**SSID_W
//  TAG_W      7      stored tag width
//  NLKP       4      lookup ports (rename slots)
//  NUPD       4      update ports (rename slots; slot k = lookup slot k)
//  NINV       2      retire invalidate ports
//  CLR_PERIOD 16384  cycles between periodic clears; 0 = disabled
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             async, active-high
//  flush_in   in   1             pipeline flush: invalidate all entries
//  lkp_ssid   in   NLKP*SSID_W   lookup SSID, slot k at [k*SSID_W +: SSID_W]
//  lkp_vld    in   NLKP          lookup request per slot
//  upd_ssid   in   NUPD*SSID_W   SSID to update per slot
//  upd_tag    in   NUPD*TAG_W    store tag to write per slot
//  upd_vld    in   NUPD          update enable per slot
//  inv_tag    in   NINV*TAG_W    tag of retiring store
//  inv_vld    in   NINV          invalidate enable
//  lfs_tag    out  NLKP*TAG_W    last-fetched-store tag per lookup
//  lfs_vld    out  NLKP          tag valid (dependence exists)
//  lfs_byp    out  NLKP          result came from same-cycle bypass
//  clr_pulse  out  1             high for the one cycle of a periodic clear
// BEHAVIOUR
//  Reset:
//   - all entry valid bits, tags and the period counter clear to 0
//   - lfs_vld=0, lfs_byp=0, lfs_tag=0, clr_pulse=0
//  Lookup:
//   - combinational, zero latency; reads registered state plus bypass
//   - Bypass: for slot k, take the highest update slot j<k with upd_vld[j] and upd_ssid[j]==lkp_ssid[k]
//     - if found: lfs_tag=upd_tag[j], lfs_vld=lkp_vld[k], lfs_byp=lkp_vld[k]
//     - else: lfs_tag=table tag, lfs_vld=lkp_vld[k] & entry valid, lfs_byp=0
//   - update slot j>=k never bypasses to lookup slot k
//   - lfs_tag is don't-care when lfs_vld=0
//  Update:
//   - registered; visible to lookups the next cycle
//   - same SSID on several slots: highest slot index wins tag and valid
//  Invalidate:
//   - every entry with valid=1 and tag==inv_tag[i] (inv_vld[i]) clears valid next edge
//   - multiple entries may match
//   - same-cycle update to the same entry wins; entry ends valid with the new tag
//  Period counter:
//   - counts 0..CLR_PERIOD-1 then wraps to 0
//   - at count CLR_PERIOD-1: clr_pulse=1 (combinational on count) and all valid bits clear at that edge
//   - not reset by flush
//  Priority per entry at an edge: reset > flush_in > periodic clear > update > invalidate > hold
//   - updates coinciding with flush or clear are dropped
//   - flush/clear do not affect same-cycle lookup outputs
//  Tags are never cleared except by reset; only valid bits change.
// TESTING
//  1. Reset, then lookup all 4 slots, SSID 0..3, lkp_vld=4'hF -> lfs_vld=0, lfs_byp=0
//  2. upd slot1 SSID 5 tag 0x22; next cycle lookup slot0 SSID 5 -> lfs_tag0=0x22, lfs_vld0=1, byp0=0
//  3. Same cycle: upd slot0 SSID 9 tag 0x11, upd slot2 SSID 9 tag 0x33, lookups SSID 9 on slots 1 and 3
//     -> slot1 tag 0x11 byp=1; slot3 tag 0x33 byp=1; next cycle table SSID 9 = 0x33
//  4. SSIDs 4 and 7 both hold tag 0x40; inv tag 0x40 while upd SSID 7 tag 0x41
//     -> next cycle SSID 4 invalid, SSID 7 valid with tag 0x41
//  5. CLR_PERIOD=8: fill SSIDs 0..3
//     -> clr_pulse high on cycle 7 after reset, then every 8 cycles; all lfs_vld=0 afterwards
//  6. flush_in with simultaneous upd SSID 2 tag 0x05 -> next cycle SSID 2 invalid
//     - assert reset mid-bundle -> all outputs 0 immediately

Source files
------------

// File: rtl/lfst_multi.sv
// Last-fetched-store table for store-set dependence prediction at rename.
// Lookups are combinational with intra-bundle bypass; updates, invalidates and clears take effect at the next edge.
module lfst_multi #(
  parameter int SSID_W     = 7,
  parameter int TAG_W      = 7,
  parameter int NLKP       = 4,
  parameter int NUPD       = 4,
  parameter int NINV       = 2,
  parameter int CLR_PERIOD = 16384
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_in,
  input  logic [NLKP*SSID_W-1:0]   lkp_ssid,
  input  logic [NLKP-1:0]          lkp_vld,
  input  logic [NUPD*SSID_W-1:0]   upd_ssid,
  input  logic [NUPD*TAG_W-1:0]    upd_tag,
  input  logic [NUPD-1:0]          upd_vld,
  input  logic [NINV*TAG_W-1:0]    inv_tag,
  input  logic [NINV-1:0]          inv_vld,
  output logic [NLKP*TAG_W-1:0]    lfs_tag,
  output logic [NLKP-1:0]          lfs_vld,
  output logic [NLKP-1:0]          lfs_byp,
  output logic                     clr_pulse
);

  localparam int   DEPTH    = 1 << SSID_W;
  localparam int   CNT_W    = (CLR_PERIOD > 1) ? $clog2(CLR_PERIOD) : 1;
  localparam int   CLR_LAST = (CLR_PERIOD > 0) ? CLR_PERIOD - 1 : 0;
  localparam logic CLR_EN   = (CLR_PERIOD > 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_LAST);

  logic [DEPTH-1:0] valid_r;
  logic [TAG_W-1:0] tag_r [DEPTH];
  logic [DEPTH-1:0] valid_nxt_s;
  logic [TAG_W-1:0] tag_nxt_s [DEPTH];
  logic [CNT_W-1:0] cnt_r;
  logic             clr_s;

  assign clr_s = CLR_EN && (cnt_r == CNT_LAST);

  // Period counter: free-running, unaffected by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!CLR_EN || (cnt_r == CNT_LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Per-entry next state: flush > clear > update (highest slot wins) > invalidate > hold.
  always_comb begin
    logic             upd_hit_v;
    logic [TAG_W-1:0] upd_tag_v;
    logic             inv_hit_v;
    for (int e = 0; e < DEPTH; e++) begin
      upd_hit_v = 1'b0;
      upd_tag_v = '0;
      inv_hit_v = 1'b0;
      for (int j = 0; j < NUPD; j++) begin
        if (upd_vld[j] && (upd_ssid[j*SSID_W +: SSID_W] == SSID_W'(e))) begin
          upd_hit_v = 1'b1;
          upd_tag_v = upd_tag[j*TAG_W +: TAG_W];
        end else begin
          upd_hit_v = upd_hit_v;
        end
      end
      for (int i = 0; i < NINV; i++) begin
        if (inv_vld[i] && (tag_r[e] == inv_tag[i*TAG_W +: TAG_W])) begin
          inv_hit_v = 1'b1;
        end else begin
          inv_hit_v = inv_hit_v;
        end
      end
      valid_nxt_s[e] = valid_r[e];
      tag_nxt_s[e]   = tag_r[e];
      if (flush_in || clr_s) begin
        valid_nxt_s[e] = 1'b0;
      end else if (upd_hit_v) begin
        valid_nxt_s[e] = 1'b1;
        tag_nxt_s[e]   = upd_tag_v;
      end else if (inv_hit_v) begin
        valid_nxt_s[e] = 1'b0;
      end else begin
        valid_nxt_s[e] = valid_r[e];
      end
    end
  end

  // Table storage; tags only ever clear on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tag_r[e] <= '0;
      end
    end else begin
      valid_r <= valid_nxt_s;
      for (int e = 0; e < DEPTH; e++) begin
        tag_r[e] <= tag_nxt_s[e];
      end
    end
  end

  // Lookup with bypass from earlier update slots; outputs forced low while reset is held.
  always_comb begin
    logic [SSID_W-1:0] ssid_v;
    lfs_tag   = '0;
    lfs_vld   = '0;
    lfs_byp   = '0;
    clr_pulse = 1'b0;
    ssid_v    = '0;
    if (reset) begin
      clr_pulse = 1'b0;
    end else begin
      clr_pulse = clr_s;
      for (int k = 0; k < NLKP; k++) begin
        ssid_v = lkp_ssid[k*SSID_W +: SSID_W];
        lfs_tag[k*TAG_W +: TAG_W] = tag_r[ssid_v];
        lfs_vld[k] = lkp_vld[k] & valid_r[ssid_v];
        lfs_byp[k] = 1'b0;
        for (int j = 0; j < NUPD; j++) begin
          if ((j < k) && upd_vld[j] && (upd_ssid[j*SSID_W +: SSID_W] == ssid_v)) begin
            lfs_tag[k*TAG_W +: TAG_W] = upd_tag[j*TAG_W +: TAG_W];
            lfs_vld[k] = lkp_vld[k];
            lfs_byp[k] = lkp_vld[k];
          end else begin
            lfs_byp[k] = lfs_byp[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfst_multi.sv
// Directed self-checking bench for lfst_multi with a short clear period.
module tb_lfst_multi;
  localparam int SW = 7;
  localparam int TW = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush_in;
  logic [4*SW-1:0] lkp_ssid;
  logic [3:0]    lkp_vld;
  logic [4*SW-1:0] upd_ssid;
  logic [4*TW-1:0] upd_tag;
  logic [3:0]    upd_vld;
  logic [2*TW-1:0] inv_tag;
  logic [1:0]    inv_vld;
  logic [4*TW-1:0] lfs_tag;
  logic [3:0]    lfs_vld;
  logic [3:0]    lfs_byp;
  logic          clr_pulse;

  int total = 0;
  int bad   = 0;

  lfst_multi #(.SSID_W(SW), .TAG_W(TW), .NLKP(4), .NUPD(4), .NINV(2), .CLR_PERIOD(8)) dut (
    .clock(clock), .reset(reset), .flush_in(flush_in),
    .lkp_ssid(lkp_ssid), .lkp_vld(lkp_vld),
    .upd_ssid(upd_ssid), .upd_tag(upd_tag), .upd_vld(upd_vld),
    .inv_tag(inv_tag), .inv_vld(inv_vld),
    .lfs_tag(lfs_tag), .lfs_vld(lfs_vld), .lfs_byp(lfs_byp), .clr_pulse(clr_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush_in = 1'b0;
    lkp_ssid = '0; lkp_vld = '0;
    upd_ssid = '0; upd_tag = '0; upd_vld = '0;
    inv_tag  = '0; inv_vld = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_lkp(input int k, input logic [SW-1:0] s);
    lkp_ssid[k*SW +: SW] = s;
    lkp_vld[k] = 1'b1;
  endtask

  task automatic set_upd(input int j, input logic [SW-1:0] s, input logic [TW-1:0] t);
    upd_ssid[j*SW +: SW] = s;
    upd_tag[j*TW +: TW]  = t;
    upd_vld[j] = 1'b1;
  endtask

  function automatic logic [TW-1:0] tag_of(input int k);
    return lfs_tag[k*TW +: TW];
  endfunction

  initial begin
    int n;
    do_reset();

    // reset state: lookups on 0..3 see nothing
    for (int k = 0; k < 4; k++) set_lkp(k, SW'(k));
    #2;
    check("rst_vld", 32'(lfs_vld), 32'h0);
    check("rst_byp", 32'(lfs_byp), 32'h0);
    check("rst_clr", 32'(clr_pulse), 32'h0);

    // update then next-cycle lookup from table
    idle();
    set_upd(1, 7'd5, 7'h22);
    tick();  // count 1
    idle();
    set_lkp(0, 7'd5);
    #2;
    check("t2_tag0", 32'(tag_of(0)), 32'h22);
    check("t2_vld0", 32'(lfs_vld[0]), 32'h1);
    check("t2_byp0", 32'(lfs_byp[0]), 32'h0);

    // intra-bundle bypass, lower slots only
    idle();
    set_upd(0, 7'd9, 7'h11);
    set_upd(2, 7'd9, 7'h33);
    set_lkp(1, 7'd9);
    set_lkp(3, 7'd9);
    #2;
    check("t3_tag1", 32'(tag_of(1)), 32'h11);
    check("t3_byp1", 32'(lfs_byp[1]), 32'h1);
    check("t3_vld1", 32'(lfs_vld[1]), 32'h1);
    check("t3_tag3", 32'(tag_of(3)), 32'h33);
    check("t3_byp3", 32'(lfs_byp[3]), 32'h1);
    tick();  // count 2
    idle();
    set_lkp(0, 7'd9);
    set_upd(0, 7'd4, 7'h40);
    set_upd(1, 7'd7, 7'h40);
    #2;
    check("t3_tbl_tag", 32'(tag_of(0)), 32'h33);
    check("t3_tbl_byp", 32'(lfs_byp[0]), 32'h0);
    tick();  // count 3

    // invalidate by tag vs same-cycle update
    idle();
    inv_tag[TW-1:0] = 7'h40;
    inv_vld = 2'b01;
    set_upd(0, 7'd7, 7'h41);
    set_lkp(1, 7'd4);
    #2;
    check("t4_pre_vld", 32'(lfs_vld[1]), 32'h1);
    check("t4_pre_tag", 32'(tag_of(1)), 32'h40);
    tick();  // count 4
    idle();
    set_lkp(0, 7'd4);
    set_lkp(1, 7'd7);
    set_lkp(2, 7'd9);
    #2;
    check("t4_ssid4_vld", 32'(lfs_vld[0]), 32'h0);
    check("t4_ssid7_vld", 32'(lfs_vld[1]), 32'h1);
    check("t4_ssid7_tag", 32'(tag_of(1)), 32'h41);
    check("t4_ssid9_vld", 32'(lfs_vld[2]), 32'h1);
    tick();  // count 5

    // flush drops the coincident update but not this cycle's lookups
    idle();
    flush_in = 1'b1;
    set_upd(0, 7'd2, 7'h05);
    set_lkp(2, 7'd9);
    #2;
    check("t6_same_cyc", 32'(lfs_vld[2]), 32'h1);
    tick();  // count 6
    idle();
    set_lkp(0, 7'd2);
    set_lkp(1, 7'd9);
    #2;
    check("t6_post_vld", 32'(lfs_vld), 32'h0);
    check("t6_no_clr", 32'(clr_pulse), 32'h0);
    tick();  // count 7
    check("t6_clr7", 32'(clr_pulse), 32'h1);

    // periodic clear
    do_reset();
    for (int k = 0; k < 4; k++) set_upd(k, SW'(k), TW'(8'h10 + k));
    tick();  // count 1
    idle();
    for (int k = 0; k < 4; k++) set_lkp(k, SW'(k));
    #2;
    check("t5_fill_vld", 32'(lfs_vld), 32'hF);
    check("t5_fill_tag2", 32'(tag_of(2)), 32'h12);
    n = 1;
    while (!clr_pulse && n < 20) begin
      tick();
      n++;
    end
    check("t5_first_pulse", 32'(n), 32'd7);
    check("t5_vld_at_pulse", 32'(lfs_vld), 32'hF);
    set_upd(0, 7'd10, 7'h7F);
    tick();  // count 0
    upd_vld = '0;
    #2;
    check("t5_cleared", 32'(lfs_vld), 32'h0);
    check("t5_pulse_low", 32'(clr_pulse), 32'h0);
    set_lkp(0, 7'd10);
    #2;
    check("t5_upd_dropped", 32'(lfs_vld[0]), 32'h0);
    n = 0;
    while (!clr_pulse && n < 20) begin
      tick();
      n++;
    end
    check("t5_period", 32'(n), 32'd7);

    // reset asserted mid-bundle forces outputs low at once
    idle();
    set_upd(0, 7'd3, 7'h2A);
    set_lkp(1, 7'd3);
    #2;
    check("t7_byp_before", 32'(lfs_byp[1]), 32'h1);
    reset = 1'b1;
    #1;
    check("t7_vld", 32'(lfs_vld), 32'h0);
    check("t7_byp", 32'(lfs_byp), 32'h0);
    check("t7_tag", lfs_tag, 32'h0);
    check("t7_clr", 32'(clr_pulse), 32'h0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
